// File: rtl/data_memory_ctrl.sv
// Multi-cycle MIPS data memory with request/Ready handshake and WAIT_STATES busy cycles.
// Define DMEM_SUBWORD_EN to enable byte/half accesses with sign/zero extension.
module data_memory_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] DataIn,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] DataOut,
  output logic        Ready,
  output logic        Error
);
  // state | meaning
  // IDLE  | waiting for MemRead/MemWrite
  // BUSY  | counting wait states, array access on terminal count
  // DONE  | one-cycle Ready pulse (Error if misaligned), then IDLE
  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam int         AW    = ADDR_WIDTH + 2;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  stateT         state, stateNext;
  logic [3:0]    cnt, cntNext;
  logic          accept, doAccess, reqMis, memWe;
  logic [AW-1:0] addrR;
  logic [31:0]   dataR;
  logic          wrR, misR;

  // Array is never touched by rst; contents survive reset.
  logic [31:0]   mem [0:DEPTH-1];

  logic          live;
  logic [AW-1:0] effAddr;
  logic [31:0]   effData;
  logic          effWrite;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]   curWord, wrWord, rdWord;
  logic          unusedBits;

  // A zero-wait access happens on the acceptance edge, so it must use live inputs.
  assign live     = (state == IDLE);
  assign effAddr  = live ? Address[AW-1:0] : addrR;
  assign effData  = live ? DataIn : dataR;
  assign effWrite = live ? MemWrite : wrR;
  assign idx      = effAddr[AW-1:2];
  assign curWord  = mem[idx];

`ifdef DMEM_SUBWORD_EN
  logic [1:0] sizeR, effSize;
  logic       unsR, effUns;
  logic [7:0] byteV;
  logic [15:0] halfV;

  assign effSize    = live ? Size : sizeR;
  assign effUns     = live ? Unsigned : unsR;
  assign unusedBits = ^Address[31:AW];

  always_comb begin
    case (Size)
      2'b00:   reqMis = 1'b0;
      2'b01:   reqMis = Address[0];
      default: reqMis = |Address[1:0];
    endcase
  end

  always_comb begin
    wrWord = curWord;
    rdWord = curWord;
    byteV  = curWord[{effAddr[1:0], 3'b000} +: 8];
    halfV  = curWord[{effAddr[1], 4'b0000} +: 16];
    case (effSize)
      2'b00: begin
        wrWord[{effAddr[1:0], 3'b000} +: 8] = effData[7:0];
        rdWord = effUns ? {24'h0, byteV} : {{24{byteV[7]}}, byteV};
      end
      2'b01: begin
        wrWord[{effAddr[1], 4'b0000} +: 16] = effData[15:0];
        rdWord = effUns ? {16'h0, halfV} : {{16{halfV[15]}}, halfV};
      end
      default: wrWord = effData;
    endcase
  end
`else
  assign unusedBits = ^{Address[31:AW], effAddr[1:0], Size, Unsigned};

  always_comb begin
    reqMis = |Address[1:0];
    wrWord = effData;
    rdWord = curWord;
  end
`endif

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    accept    = 1'b0;
    doAccess  = 1'b0;
    case (state)
      IDLE: begin
        if (MemRead || MemWrite) begin
          accept  = 1'b1;
          cntNext = WS;
          if (reqMis) begin
            stateNext = DONE;
          end else if (WS == 4'd0) begin
            stateNext = DONE;
            doAccess  = 1'b1;
          end else begin
            stateNext = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt <= 4'd1) begin
          doAccess  = 1'b1;
          cntNext   = 4'd0;
          stateNext = DONE;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      DataOut <= 32'h0;
      addrR   <= '0;
      dataR   <= 32'h0;
      wrR     <= 1'b0;
      misR    <= 1'b0;
`ifdef DMEM_SUBWORD_EN
      sizeR   <= 2'b00;
      unsR    <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        addrR <= Address[AW-1:0];
        dataR <= DataIn;
        wrR   <= MemWrite;
        misR  <= reqMis;
`ifdef DMEM_SUBWORD_EN
        sizeR <= Size;
        unsR  <= Unsigned;
`endif
      end
      if (doAccess && !effWrite) DataOut <= rdWord;
    end
  end

  // Gating with rst drops a pending write on a reset edge.
  assign memWe = doAccess & effWrite & ~rst;

  always_ff @(posedge clk) begin
    if (memWe) mem[idx] <= wrWord;
  end

  assign Ready = (state == DONE);
  assign Error = Ready & misR;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl (ADDR_WIDTH=8, WAIT_STATES=2).
module tb_data_memory_ctrl;
  localparam int AW = 8;
  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite, Unsigned;
  logic [31:0] Address, DataIn, DataOut;
  logic [1:0]  Size;
  logic        Ready, Error;

  int total = 0;
  int bad   = 0;
  logic [31:0] lastOut;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    string       tag;
  } expT;
  expT sbQ[$];

  always #5 clk = ~clk;

  data_memory_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .DataIn(DataIn), .Size(Size), .Unsigned(Unsigned),
    .DataOut(DataOut), .Ready(Ready), .Error(Error)
  );

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [1:0] size, input logic uns,
                        input logic [31:0] expData, input logic expErr, input string tag);
    expT e, got;
    int cyc;
    e.data = expData;
    e.err  = expErr;
    e.lat  = expErr ? 1 : WS + 1;
    e.tag  = tag;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Address = addr; DataIn = data; Size = size; Unsigned = uns;
    sbQ.push_back(e);
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (Ready !== 1'b1 && cyc < 50);
    MemRead = 1'b0; MemWrite = 1'b0;
    got = sbQ.pop_front();
    total++;
    if (Ready !== 1'b1) begin
      bad++;
      $display("FAIL %s timeout: Ready still %b after %0d cycles", got.tag, Ready, cyc);
    end else begin
      total++;
      if (cyc != got.lat) begin
        bad++;
        $display("FAIL %s latency: got %0d want %0d", got.tag, cyc, got.lat);
      end
      total++;
      if (DataOut !== got.data) begin
        bad++;
        $display("FAIL %s DataOut: got %h want %h", got.tag, DataOut, got.data);
      end
      total++;
      if (Error !== got.err) begin
        bad++;
        $display("FAIL %s Error: got %b want %b", got.tag, Error, got.err);
      end
    end
    lastOut = got.data;
    @(negedge clk);
    total++;
    if (Ready !== 1'b0 || Error !== 1'b0) begin
      bad++;
      $display("FAIL %s pulse: Ready=%b Error=%b want 0 0", got.tag, Ready, Error);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = '0; DataIn = '0; Size = 2'b10; Unsigned = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (Ready !== 1'b0 || Error !== 1'b0 || DataOut !== 32'h0) begin
      bad++;
      $display("FAIL reset: Ready=%b Error=%b DataOut=%h want 0 0 00000000", Ready, Error, DataOut);
    end
    rst = 1'b0;
    lastOut = 32'h0;
  endtask

  task automatic test_word;
    access(0, 1, 32'd0, 32'h0000ABCD, 2'b10, 0, lastOut, 0, "wr0");
    access(0, 1, 32'd4, 32'h00001234, 2'b10, 0, lastOut, 0, "wr4");
    access(1, 0, 32'd4, 32'h0, 2'b10, 0, 32'h00001234, 0, "rd4");
    access(1, 0, 32'd0, 32'h0, 2'b10, 0, 32'h0000ABCD, 0, "rd0");
  endtask

  task automatic test_both;
    access(1, 1, 32'd0, 32'h00001234, 2'b10, 0, 32'h0000ABCD, 0, "rdwr0");
    access(1, 0, 32'd0, 32'h0, 2'b10, 0, 32'h00001234, 0, "rd0_after_rdwr");
  endtask

  task automatic test_subword;
`ifdef DMEM_SUBWORD_EN
    access(0, 1, 32'd8,  32'h11223344, 2'b10, 0, lastOut, 0, "wr8");
    access(0, 1, 32'd9,  32'h000000FF, 2'b00, 0, lastOut, 0, "sb9");
    access(1, 0, 32'd8,  32'h0, 2'b10, 0, 32'h1122FF44, 0, "lw8");
    access(1, 0, 32'd9,  32'h0, 2'b00, 0, 32'hFFFFFFFF, 0, "lb9");
    access(1, 0, 32'd9,  32'h0, 2'b00, 1, 32'h000000FF, 0, "lbu9");
    access(1, 0, 32'd10, 32'h0, 2'b01, 0, 32'h00001122, 0, "lh10");
    access(1, 0, 32'd8,  32'h0, 2'b01, 0, 32'hFFFFFF44, 0, "lh8");
    access(1, 0, 32'd8,  32'h0, 2'b01, 1, 32'h0000FF44, 0, "lhu8");
    access(1, 0, 32'd9,  32'h0, 2'b01, 0, lastOut, 1, "lh9_mis");
    access(0, 1, 32'd10, 32'h0000BEEF, 2'b01, 0, lastOut, 0, "sh10");
    access(1, 0, 32'd8,  32'h0, 2'b11, 0, 32'hBEEFFF44, 0, "lw8_size11");
`else
    access(0, 1, 32'd8, 32'h11223344, 2'b00, 0, lastOut, 0, "wr8_sizeignored");
    access(1, 0, 32'd8, 32'h0, 2'b00, 1, 32'h11223344, 0, "rd8_sizeignored");
    access(0, 1, 32'd9, 32'h000000FF, 2'b00, 0, lastOut, 1, "sb9_mis");
    access(1, 0, 32'd8, 32'h0, 2'b01, 0, 32'h11223344, 0, "rd8_unchanged");
`endif
  endtask

  task automatic test_misaligned;
    access(1, 0, 32'd2, 32'h0, 2'b10, 0, lastOut, 1, "rd2_mis");
    access(0, 1, 32'd2, 32'hFFFFFFFF, 2'b10, 0, lastOut, 1, "wr2_mis");
    access(1, 0, 32'd0, 32'h0, 2'b10, 0, 32'h00001234, 0, "rd0_after_mis");
  endtask

  task automatic test_reset_busy;
    access(0, 1, 32'd12, 32'h01020304, 2'b10, 0, lastOut, 0, "wr12");
    access(1, 0, 32'd12, 32'h0, 2'b10, 0, 32'h01020304, 0, "rd12");
    @(negedge clk);
    MemWrite = 1'b1; Address = 32'd12; DataIn = 32'hDEADBEEF; Size = 2'b10;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (Ready !== 1'b0 || DataOut !== 32'h0) begin
      bad++;
      $display("FAIL rst_busy: Ready=%b DataOut=%h want 0 00000000", Ready, DataOut);
    end
    rst = 1'b0; MemWrite = 1'b0;
    lastOut = 32'h0;
    access(1, 0, 32'd12, 32'h0, 2'b10, 0, 32'h01020304, 0, "rd12_after_rst");
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      access(0, 1, 32'(80 + 4 * i), vals[i], 2'b10, 0, lastOut, 0, "b2b_wr");
    end
    for (int i = 0; i < 4; i++)
      access(1, 0, 32'(80 + 4 * i), 32'h0, 2'b11, 0, vals[i], 0, "b2b_rd");
  endtask

  task automatic test_wrap;
    access(0, 1, 32'h400, 32'h5A5A5A5A, 2'b10, 0, lastOut, 0, "wr400");
    access(1, 0, 32'h000, 32'h0, 2'b10, 0, 32'h5A5A5A5A, 0, "rd0_wrap");
  endtask

  initial begin
    test_reset();
    test_word();
    test_both();
    test_subword();
    test_misaligned();
    test_reset_busy();
    test_back_to_back();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
